// File: rtl/regbus_initiator.sv
// regbus_initiator: bus initiator for the register-bus slave interface.
//
// Accepts one read, write or read-modify-write command at a time on a
// valid/ready command port, sequences the slave strobes and returns read
// data or an error on a valid/ready response port.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake (cmd_ready = idle)
//   cmd_op                          00 read, 01 write, 10 RMW, 11 reserved
//   cmd_addr/cmd_wdata/cmd_mask     command address, data, RMW bit mask
//   resp_valid/resp_ready           response handshake
//   resp_rdata/resp_err             response data and error flag
//   bus_*                           register-bus slave signals
module regbus_initiator #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [DATA_WIDTH-1:0] cmd_mask,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  bus_chip_select,
  output logic                  bus_write_en,
  output logic                  bus_read_en,
  output logic [DATA_WIDTH-1:0] bus_write_data,
  input  logic [DATA_WIDTH-1:0] bus_read_data,
  input  logic                  bus_data_valid
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] OpRead  = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpRmw   = 2'b10;

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StMwrite, StResp} state_e;

  state_e                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] cap_q, cap_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  // Registered outputs.
  logic                  cs_q, cs_d;
  logic                  we_q, we_d;
  logic                  re_q, re_d;
  logic [ADDR_WIDTH-1:0] baddr_q, baddr_d;
  logic [DATA_WIDTH-1:0] bwdata_q, bwdata_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rerr_q, rerr_d;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mask_d   = mask_q;
    cap_d    = cap_q;
    cnt_d    = cnt_q;
    // Strobes, address and write data fall back to 0 unless a state drives them.
    cs_d     = 1'b0;
    we_d     = 1'b0;
    re_d     = 1'b0;
    baddr_d  = '0;
    bwdata_d = '0;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (cmd_valid) begin
          op_d    = cmd_op;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          mask_d  = cmd_mask;
          if (cmd_op == OpWrite) begin
            state_d  = StWrite;
            cs_d     = 1'b1;
            we_d     = 1'b1;
            baddr_d  = cmd_addr;
            bwdata_d = cmd_wdata;
          end else if (cmd_op == OpRead || cmd_op == OpRmw) begin
            state_d = StRead;
            cs_d    = 1'b1;
            re_d    = 1'b1;
            baddr_d = cmd_addr;
          end else begin
            // Reserved op: error response without touching the bus.
            state_d  = StResp;
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rerr_d   = 1'b1;
          end
        end
      end

      StWrite: begin
        state_d  = StResp;
        rvalid_d = 1'b1;
        rdata_d  = '0;
        rerr_d   = 1'b0;
      end

      StRead: begin
        // Data valid wins over timeout when both land in the last allowed cycle.
        if (bus_data_valid) begin
          cap_d = bus_read_data;
          if (op_q == OpRmw) begin
            state_d  = StMwrite;
            cs_d     = 1'b1;
            we_d     = 1'b1;
            baddr_d  = addr_q;
            bwdata_d = (bus_read_data & ~mask_q) | (wdata_q & mask_q);
          end else begin
            state_d  = StResp;
            rvalid_d = 1'b1;
            rdata_d  = bus_read_data;
            rerr_d   = 1'b0;
          end
        end else if (cnt_q == CntLast) begin
          state_d  = StResp;
          rvalid_d = 1'b1;
          rdata_d  = '0;
          rerr_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          cs_d    = 1'b1;
          re_d    = 1'b1;
          baddr_d = addr_q;
        end
      end

      StMwrite: begin
        state_d  = StResp;
        rvalid_d = 1'b1;
        rdata_d  = cap_q;
        rerr_d   = 1'b0;
      end

      StResp: begin
        if (resp_ready) begin
          state_d  = StIdle;
          rvalid_d = 1'b0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
      cap_q    <= '0;
      cnt_q    <= '0;
      cs_q     <= 1'b0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      baddr_q  <= '0;
      bwdata_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mask_q   <= mask_d;
      cap_q    <= cap_d;
      cnt_q    <= cnt_d;
      cs_q     <= cs_d;
      we_q     <= we_d;
      re_q     <= re_d;
      baddr_q  <= baddr_d;
      bwdata_q <= bwdata_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
    end
  end

  assign cmd_ready       = (state_q == StIdle);
  assign resp_valid      = rvalid_q;
  assign resp_rdata      = rdata_q;
  assign resp_err        = rerr_q;
  assign bus_addr        = baddr_q;
  assign bus_chip_select = cs_q;
  assign bus_write_en    = we_q;
  assign bus_read_en     = re_q;
  assign bus_write_data  = bwdata_q;

endmodule

// File: tb/tb_regbus_initiator.sv
// Testbench for regbus_initiator: memory-backed slave with configurable
// read latency, directed scenarios followed by randomized commands.
module tb_regbus_initiator;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [7:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [31:0] cmd_mask = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [7:0]  bus_addr;
  logic        bus_chip_select;
  logic        bus_write_en;
  logic        bus_read_en;
  logic [31:0] bus_write_data;
  logic [31:0] bus_read_data;
  logic        bus_data_valid;

  int checks = 0;
  int errors = 0;
  int viol = 0;

  always #5 clk = ~clk;

  regbus_initiator #(
    .ADDR_WIDTH    (8),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_addr       (cmd_addr),
    .cmd_wdata      (cmd_wdata),
    .cmd_mask       (cmd_mask),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .bus_addr       (bus_addr),
    .bus_chip_select(bus_chip_select),
    .bus_write_en   (bus_write_en),
    .bus_read_en    (bus_read_en),
    .bus_write_data (bus_write_data),
    .bus_read_data  (bus_read_data),
    .bus_data_valid (bus_data_valid)
  );

  // Slave: data_valid comes slave_lat cycles after read_en rises.
  logic [31:0] mem [256];
  logic [31:0] exp_mem [256];
  int          slave_lat = 1;
  int          rd_cnt;
  logic        stray = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_cnt <= 0;
    else if (bus_chip_select && bus_read_en) rd_cnt <= rd_cnt + 1;
    else rd_cnt <= 0;
  end

  always @(posedge clk) begin
    if (bus_chip_select && bus_write_en) mem[bus_addr] <= bus_write_data;
  end

  assign bus_read_data  = (bus_chip_select && bus_read_en) ? mem[bus_addr] : 32'hBAD0_BAD0;
  assign bus_data_valid = stray || (bus_chip_select && bus_read_en && (rd_cnt >= slave_lat));

  // Bus protocol rules, accumulated and checked once at the end.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_write_en && bus_read_en) viol++;
      if ((bus_write_en || bus_read_en) && !bus_chip_select) viol++;
      if (bus_chip_select && !bus_write_en && !bus_read_en) viol++;
      if (!bus_chip_select && (bus_addr != 0 || bus_write_data != 0)) viol++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command and check strobes, latency and response against the
  // reference memory. lat >= TIMEOUT means the slave never answers in time.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] a, input logic [31:0] wd,
                         input logic [31:0] m, input int lat, input int hold);
    bit          is_rd, to;
    int          e_re, e_we, e_lat, e_wcyc;
    logic [31:0] e_rd, e_wd, old;
    logic        e_err;
    int          re_n = 0, we_n = 0, wcyc = 0, got = 0;
    logic [31:0] wdat = '0;
    logic [7:0]  wadr = '0;

    is_rd = (op == 2'b00) || (op == 2'b10);
    to    = is_rd && (lat >= TIMEOUT);
    old   = exp_mem[a];
    e_re  = !is_rd ? 0 : (to ? TIMEOUT : lat + 1);
    e_we = 0; e_wd = '0; e_wcyc = 0; e_rd = '0; e_err = 1'b0;
    case (op)
      2'b00: begin
        e_lat = to ? TIMEOUT + 1 : lat + 2;
        e_rd  = to ? 32'h0 : old;
        e_err = to;
      end
      2'b01: begin
        e_lat = 2; e_we = 1; e_wd = wd; e_wcyc = 1;
      end
      2'b10: begin
        e_lat  = to ? TIMEOUT + 1 : lat + 3;
        e_we   = to ? 0 : 1;
        e_wd   = (old & ~m) | (wd & m);
        e_wcyc = lat + 2;
        e_rd   = to ? 32'h0 : old;
        e_err  = to;
      end
      default: begin
        e_lat = 1; e_err = 1'b1;
      end
    endcase

    slave_lat = lat;
    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = wd; cmd_mask = m;
    @(posedge clk);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) cmd_valid = 1'b0;
      if (bus_read_en) begin
        re_n++;
        check("read_addr", bus_addr, a);
      end
      if (bus_write_en) begin
        we_n++; wcyc = c; wadr = bus_addr; wdat = bus_write_data;
      end
      if (resp_valid) begin
        got = c;
        break;
      end
    end
    check("latency", got, e_lat);
    check("read_en_cycles", re_n, e_re);
    check("write_en_cycles", we_n, e_we);
    if (e_we != 0 && we_n != 0) begin
      check("write_addr", wadr, a);
      check("write_data", wdat, e_wd);
      check("write_cycle", wcyc, e_wcyc);
    end
    if (got == 0) return;
    check("resp_rdata", resp_rdata, e_rd);
    check("resp_err", resp_err, e_err);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", resp_valid, 1);
      check("hold_cmd_ready", cmd_ready, 0);
      check("hold_rdata", resp_rdata, e_rd);
      check("hold_err", resp_err, e_err);
      check("hold_cs", bus_chip_select, 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_dropped", resp_valid, 0);
    check("cmd_ready_back", cmd_ready, 1);
    if (e_we != 0) exp_mem[a] = e_wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      exp_mem[i] = mem[i];
    end

    // Reset values.
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_bus", {bus_chip_select, bus_write_en, bus_read_en, bus_addr, bus_write_data}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed scenarios.
    run_cmd(2'b01, 8'h04, 32'hDEAD_BEEF, 32'h0, 1, 0);
    mem[8'h04] = 32'h1234_5678; exp_mem[8'h04] = 32'h1234_5678;
    run_cmd(2'b00, 8'h04, 32'h0, 32'h0, 1, 0);
    mem[8'h08] = 32'hFFFF_0000; exp_mem[8'h08] = 32'hFFFF_0000;
    run_cmd(2'b10, 8'h08, 32'h0000_ABCD, 32'h0000_FFFF, 1, 0);
    run_cmd(2'b00, 8'h08, 32'h0, 32'h0, 1, 0);
    run_cmd(2'b00, 8'h10, 32'h0, 32'h0, 1000, 0);
    run_cmd(2'b10, 8'h11, 32'h5555_5555, 32'hFFFF_FFFF, 1000, 0);
    run_cmd(2'b00, 8'h11, 32'h0, 32'h0, 1, 0);
    run_cmd(2'b00, 8'h12, 32'h0, 32'h0, TIMEOUT - 1, 0);
    run_cmd(2'b00, 8'h13, 32'h0, 32'h0, 3, 5);
    run_cmd(2'b11, 8'h14, 32'hFFFF_FFFF, 32'h0, 1, 5);

    // Stray data_valid while not reading must be ignored.
    stray = 1'b1;
    run_cmd(2'b01, 8'h20, 32'hCAFE_F00D, 32'h0, 1, 1);
    stray = 1'b0;
    run_cmd(2'b00, 8'h20, 32'h0, 32'h0, 2, 0);

    // Reset in the middle of a read.
    slave_lat = 1000;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 8'h30;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_read_en", bus_read_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_strobes", {bus_chip_select, bus_read_en, bus_write_en}, 0);
    check("mid_rst_addr", bus_addr, 0);
    check("mid_rst_resp_valid", resp_valid, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(2'b00, 8'h30, 32'h0, 32'h0, 1, 0);

    // Randomized commands.
    for (int n = 0; n < 40; n++) begin
      int r, rl, lat;
      logic [1:0] op;
      r  = $urandom_range(0, 9);
      op = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      rl = $urandom_range(0, 9);
      lat = (rl < 7) ? $urandom_range(1, 4) : (rl == 7) ? TIMEOUT - 1 : (rl == 8) ? TIMEOUT : 1;
      run_cmd(op, 8'($urandom_range(0, 15)), $urandom, $urandom, lat, $urandom_range(0, 3));
    end

    check("protocol_violations", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regbus_initiator.md
Name: regbus_initiator

Overview:
- Bus initiator (master) that drives the team's custom register-bus slave interface: addr, chip_select, write_en, read_en, write_data, read_data, data_valid.
- Accepts single read, write and read-modify-write (RMW) commands on a valid/ready command port.
- Sequences the bus strobes, waits for data_valid on reads and returns read data or a timeout error on a valid/ready response port.
- Sits between a CPU/test-sequencer front end and any generated register-file block.

Parameters:
- ADDR_WIDTH, 8, bus address width
- DATA_WIDTH, 32, bus data width
- TIMEOUT_CYCLES, 16, max read cycles without data_valid before error (>=2)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  initiator can accept command
- cmd_op  input  2  00 read, 01 write, 10 RMW, 11 reserved
- cmd_addr  input  ADDR_WIDTH  target address
- cmd_wdata  input  DATA_WIDTH  write data / RMW new bits
- cmd_mask  input  DATA_WIDTH  RMW bit mask (1 = take cmd_wdata bit)
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts response
- resp_rdata  output  DATA_WIDTH  read data (read: value read; RMW: pre-modify value; write: 0)
- resp_err  output  1  timeout or reserved op
- bus_addr  output  ADDR_WIDTH  to slave addr
- bus_chip_select  output  1  to slave chip_select
- bus_write_en  output  1  to slave write_en
- bus_read_en  output  1  to slave read_en
- bus_write_data  output  DATA_WIDTH  to slave write_data
- bus_read_data  input  DATA_WIDTH  from slave read_data
- bus_data_valid  input  1  from slave data_valid

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: state IDLE; all bus outputs 0; resp_valid 0, resp_rdata 0, resp_err 0, timeout counter 0.
- All outputs are registered except cmd_ready, which is combinational and equals (state==IDLE).
- States: IDLE, WRITE, READ, MWRITE, RESP.
- IDLE: on cmd_valid&&cmd_ready, latch addr, wdata, mask and op.
  - op 01 -> WRITE.
  - op 00/10 -> READ.
  - op 11 -> RESP with err=1, rdata=0; no bus activity.
- WRITE: exactly one cycle of chip_select=write_en=1, bus_addr=addr, bus_write_data=wdata. Strobes assert in the cycle after acceptance. The slave gives no write ack. Next state RESP, err=0, rdata=0.
- READ: chip_select=read_en=1 and bus_addr held from the cycle after acceptance until bus_data_valid is sampled high.
  - In that cycle, capture bus_read_data. Strobes stay high through the capture cycle because the slave's read_data is combinational on read_active.
  - Deassert strobes next cycle.
  - Nominal slave: data_valid is 1 cycle after read_en, so the read strobe is 2 cycles wide.
  - Counter increments each READ cycle. If data_valid has not been seen after TIMEOUT_CYCLES cycles, deassert strobes and go to RESP with err=1, rdata=0. This applies to RMW too: no write is issued.
  - On capture: op 00 -> RESP, rdata=captured. op 10 -> MWRITE.
- MWRITE: one cycle of chip_select=write_en=1, write_data=(captured & ~mask) | (wdata & mask), same addr. Next state RESP, rdata=captured (old value), err=0.
- RESP: resp_valid=1 with stable rdata/err until resp_ready is sampled high, then IDLE. resp_valid may be high in the same cycle it is accepted. cmd_ready is 0 in RESP, so at most one transaction is outstanding.
- bus_addr and bus_write_data are 0 whenever chip_select=0.
- write_en and read_en are never high together.
- A bus_data_valid high outside READ is ignored.
- Reset asserted mid-transaction: immediate return to reset values. Strobes drop asynchronously; a pending response is discarded.
- Minimum command-to-response latency:
  - Write: 2 cycles.
  - Read: 3 cycles.
  - RMW: 4 cycles.
  - Each is measured from the acceptance edge to resp_valid high, with a nominal slave.

Test Plan:
- Write addr 0x04, data 0xDEADBEEF -> one-cycle cs/we with those values 1 cycle after accept; resp_valid next cycle, err=0, rdata=0.
- Read addr 0x04 against slave model (data_valid delayed 1 cycle, read_data = 0x12345678) -> read_en high exactly 2 cycles; resp_rdata=0x12345678, err=0.
- RMW addr 0x08, old value 0xFFFF0000, wdata 0x0000ABCD, mask 0x0000FFFF -> write_data 0xFFFFABCD; resp_rdata=0xFFFF0000.
- Read with data_valid tied 0, TIMEOUT_CYCLES=16 -> read_en high 16 cycles then low; resp_err=1, rdata=0. Same as RMW -> no write strobe.
- resp_ready held 0 for 5 cycles, then cmd_op=11 -> response held stable and cmd_ready=0 throughout; reserved op -> err=1 with no bus strobes.
- rst_n pulsed low during READ -> all strobes and resp_valid 0 immediately; next command completes normally.
